// File: rtl/mem_responder.sv
// mem_responder: word-addressed unified memory with fixed
// wait states, single-cycle ready pulse and preload port.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ready,
  output logic                     err,
  output logic                     busy,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH):0]   load_idx,
  input  logic [DATA_W-1:0]        load_data
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nx;
  logic                enter;

  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;

  logic                s_we;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic [ADDR_W-3:0]   s_word;
  logic [IW-1:0]       s_idx;
  logic                bad;
  logic                ld_ok;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state and wait-counter decode; enter marks the RESP-entry edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    enter    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            enter    = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          enter    = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the access resolves on the capture edge,
  // so the live inputs stand in for the capture registers.
  always_comb begin
    s_we    = cap_we;
    s_addr  = cap_addr;
    s_wdata = cap_wdata;
    if (state == IDLE) begin
      s_we    = we;
      s_addr  = addr;
      s_wdata = wdata;
    end
    s_word = s_addr[ADDR_W-1:2];
    s_idx  = s_addr[IW+1:2];
    bad    = (s_addr[1:0] != 2'b00) ||
             (s_word >= (ADDR_W-2)'(DEPTH));
    ld_ok  = load_we && (load_idx < (IW+1)'(DEPTH));
  end

  // State, counter and request capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
    end
  end

  // Response data and error flag; err lives only for the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (enter) begin
      if (bad) begin
        err   <= 1'b1;
        rdata <= '0;
      end else begin
        err <= 1'b0;
        if (!s_we) rdata <= mem[s_idx];
      end
    end else if (state == RESP) begin
      err <= 1'b0;
    end
  end

  // Array writes; the preload port is last so it wins a collision.
  always_ff @(posedge clk) begin
    if (enter && !bad && s_we) mem[s_idx] <= s_wdata;
    if (ld_ok) mem[load_idx[IW-1:0]] <= load_data;
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

endmodule
